// File: rtl/fft_stage_mux_seq.sv
// Registered N:1 FFT stage-operand mux with valid/ready handshake and an auto stage sequencer.
// Optional sticky out-of-range selection flag: define FFT_MUX_SEL_ERR_EN to add the sel_err port.
module fft_stage_mux_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_IN     = 5,
  parameter int SEL_W      = 3,
  parameter int FRAME_LEN  = 32,
  parameter int CNT_W      = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_bus,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         mode,
  input  logic [SEL_W-1:0]             sel_manual,
  input  logic                         start,
  output logic [DATA_WIDTH-1:0]        y,
  output logic                         y_valid,
  input  logic                         out_ready,
  output logic [SEL_W-1:0]             cur_sel,
  output logic                         busy,
  output logic                         frame_done
`ifdef FFT_MUX_SEL_ERR_EN
  ,
  output logic                         sel_err
`endif
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SEL_W-1:0]      stage_q, stage_d;
  logic [DATA_WIDTH-1:0] y_q, y_d;
  logic                  y_valid_q, y_valid_d;
  logic                  accept_s;
  logic                  cnt_wrap_s;
  logic                  last_accept_s;
  logic                  sel_oor_s;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic [DATA_WIDTH-1:0] slices_s [NUM_IN];

  for (genvar k = 0; k < NUM_IN; k++) begin : g_slice
    assign slices_s[k] = in_bus[k*DATA_WIDTH +: DATA_WIDTH];
  end

  assign accept_s      = in_valid && in_ready;
  assign cnt_wrap_s    = (cnt_q == CNT_W'(FRAME_LEN - 1));
  assign last_accept_s = (state_q == RUN) && accept_s && cnt_wrap_s
                         && (stage_q == SEL_W'(NUM_IN - 1));
  assign sel_oor_s     = (32'(cur_sel) >= NUM_IN);
  assign sel_data_s    = sel_oor_s ? {DATA_WIDTH{1'b0}} : slices_s[cur_sel];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (start && mode) ? RUN : IDLE;
      RUN:     state_d = last_accept_s ? IDLE : RUN;
      default: state_d = IDLE;
    endcase
  end

  // Auto mode in IDLE blocks input so no sample slips in before start.
  always_comb begin
    busy       = 1'b0;
    cur_sel    = {SEL_W{1'b0}};
    in_ready   = !y_valid_q || out_ready;
    frame_done = last_accept_s && !rst;
    case (state_q)
      IDLE: begin
        cur_sel  = mode ? {SEL_W{1'b0}} : sel_manual;
        in_ready = (!y_valid_q || out_ready) && !mode;
      end
      RUN: begin
        busy    = 1'b1;
        cur_sel = stage_q;
      end
      default: begin
        busy    = 1'b0;
        cur_sel = {SEL_W{1'b0}};
      end
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    stage_d   = stage_q;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    if (accept_s) begin
      y_d       = sel_data_s;
      y_valid_d = 1'b1;
    end else if (out_ready) begin
      y_valid_d = 1'b0;
    end else begin
      y_valid_d = y_valid_q;
    end
    if (state_q != RUN) begin
      cnt_d   = {CNT_W{1'b0}};
      stage_d = {SEL_W{1'b0}};
    end else if (accept_s && cnt_wrap_s) begin
      cnt_d   = {CNT_W{1'b0}};
      stage_d = last_accept_s ? {SEL_W{1'b0}} : stage_q + SEL_W'(1);
    end else if (accept_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= {CNT_W{1'b0}};
      stage_q   <= {SEL_W{1'b0}};
      y_q       <= {DATA_WIDTH{1'b0}};
      y_valid_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      stage_q   <= stage_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;

`ifdef FFT_MUX_SEL_ERR_EN
  logic sel_err_q, sel_err_d;

  assign sel_err_d = sel_err_q || (accept_s && sel_oor_s);

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_fft_stage_mux_seq.sv
// Scoreboard bench for fft_stage_mux_seq: manual select, out-of-range, auto sequence,
// backpressure, reset mid-run and ignored restart.
module tb_fft_stage_mux_seq;

  localparam int DW = 16;
  localparam int NI = 5;
  localparam int SW = 3;

  logic            clk = 1'b0;
  logic            rst, in_valid, mode, start, out_ready;
  logic [NI*DW-1:0] in_bus;
  logic [SW-1:0]   sel_manual;
  logic            in_ready, y_valid, busy, frame_done;
  logic [DW-1:0]   y;
  logic [SW-1:0]   cur_sel;
`ifdef FFT_MUX_SEL_ERR_EN
  logic            sel_err;
  logic            m_err;
`endif

  fft_stage_mux_seq dut (
    .clk(clk), .rst(rst), .in_bus(in_bus), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel_manual(sel_manual), .start(start), .y(y), .y_valid(y_valid),
    .out_ready(out_ready), .cur_sel(cur_sel), .busy(busy), .frame_done(frame_done)
`ifdef FFT_MUX_SEL_ERR_EN
    , .sel_err(sel_err)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [11:0] seq;
  logic [DW-1:0] exp_q[$];
  logic          m_busy;
  int            m_cnt, m_stage, n_run_acc, fd_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Bench-owned slice pattern: input k carries {seq, k}.
  always_comb begin
    for (int k = 0; k < NI; k++) in_bus[k*DW +: DW] = {seq, 4'(k)};
  end

  // Reference model and scoreboard, evaluated mid-cycle.
  always @(negedge clk) begin
    logic [SW-1:0] es;
    logic acc, efd, busy_before;
    if (rst) begin
      exp_q.delete();
      m_busy = 1'b0; m_cnt = 0; m_stage = 0;
`ifdef FFT_MUX_SEL_ERR_EN
      m_err = 1'b0;
`endif
    end else begin
      check("y_valid", 32'(y_valid), 32'(exp_q.size() != 0));
      check("in_ready", 32'(in_ready),
            32'((exp_q.size() == 0 || out_ready) && !(!m_busy && mode)));
      check("busy", 32'(busy), 32'(m_busy));
`ifdef FFT_MUX_SEL_ERR_EN
      check("sel_err", 32'(sel_err), 32'(m_err));
`endif
      if (y_valid && out_ready && exp_q.size() != 0) check("y", 32'(y), 32'(exp_q.pop_front()));
      es = m_busy ? SW'(m_stage) : (mode ? 3'd0 : sel_manual);
      check("cur_sel", 32'(cur_sel), 32'(es));
      acc = in_valid && in_ready;
      efd = 1'b0;
      busy_before = m_busy;
      if (acc) begin
        exp_q.push_back((int'(es) < NI) ? {seq, 4'(es)} : 16'h0000);
`ifdef FFT_MUX_SEL_ERR_EN
        if (int'(es) >= NI) m_err = 1'b1;
`endif
        if (m_busy) begin
          n_run_acc++;
          if (m_cnt == 31) begin
            m_cnt = 0;
            if (m_stage == NI - 1) begin efd = 1'b1; m_busy = 1'b0; m_stage = 0; end
            else m_stage++;
          end else m_cnt++;
        end
      end
      if (frame_done || efd) begin
        check("frame_done", 32'(frame_done), 32'(efd));
        check("fd_accept_no", 32'(n_run_acc), 32'd160);
      end
      if (frame_done) fd_cnt++;
      if (start && mode && !busy_before) begin
        m_busy = 1'b1; m_cnt = 0; m_stage = 0; n_run_acc = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    seq = seq + 12'd1;
  endtask

  // Auto run until frame_done; optional restart attempt, stall and reset abort.
  task automatic auto_run(input int abort_at, input bit try_restart, input int stall_at);
    int budget, stalled, fd0;
    bit restarted;
    fd0 = fd_cnt; restarted = 1'b0; stalled = 0; budget = 0;
    mode = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    while (fd_cnt == fd0 && budget < 400) begin
      start = 1'b0;
      if (abort_at > 0 && n_run_acc >= abort_at) begin
        rst = 1'b1; tick(); rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_yvalid", 32'(y_valid), 32'd0);
        check("abort_cursel", 32'(cur_sel), 32'd0);
        check("abort_no_fd", 32'(fd_cnt), 32'(fd0));
        return;
      end
      if (try_restart && !restarted && n_run_acc == 10) begin start = 1'b1; restarted = 1'b1; end
      if (stall_at > 0 && n_run_acc == stall_at && stalled < 5) begin out_ready = 1'b0; stalled++; end
      else out_ready = 1'b1;
      tick();
      budget++;
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("run_timeout", 32'(budget < 400), 32'd1);
    check("fd_once", 32'(fd_cnt - fd0), 32'd1);
    tick(); tick();
    check("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    seq = 12'h000; rst = 1'b1; in_valid = 1'b0; mode = 1'b1; start = 1'b0;
    out_ready = 1'b1; sel_manual = 3'd0; fd_cnt = 0; n_run_acc = 0;
    m_busy = 1'b0; m_cnt = 0; m_stage = 0;
    tick(); tick();
    check("rst_y", 32'(y), 32'd0);
    check("rst_yvalid", 32'(y_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cursel", 32'(cur_sel), 32'd0);
    check("rst_fd", 32'(frame_done), 32'd0);
    rst = 1'b0; mode = 1'b0;
    // Manual select 3 on the 16'h1000+k pattern.
    @(posedge clk); #1; seq = 12'h100; sel_manual = 3'd3; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    check("manual_y1003", 32'(y), 32'h1003);
    check("manual_yvalid", 32'(y_valid), 32'd1);
    tick();
    // Sweep all selector codes, including 5..7 out of range.
    for (int s = 0; s < 8; s++) begin
      sel_manual = 3'(s); in_valid = 1'b1; tick();
    end
    in_valid = 1'b0; tick();
`ifdef FFT_MUX_SEL_ERR_EN
    check("sel_err_sticky", 32'(sel_err), 32'd1);
`endif
    // Random manual traffic with random backpressure.
    for (int i = 0; i < 40; i++) begin
      sel_manual = 3'($urandom_range(0, 7));
      in_valid   = 1'($urandom_range(0, 1));
      out_ready  = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1; tick(); tick();
    // start in manual mode is ignored.
    start = 1'b1; tick(); start = 1'b0; tick();
    check("manual_start_ign", 32'(busy), 32'd0);
    auto_run(0, 1'b0, 0);
    auto_run(0, 1'b1, 50);
    auto_run(40, 1'b0, 0);
`ifdef FFT_MUX_SEL_ERR_EN
    check("sel_err_cleared", 32'(sel_err), 32'd0);
`endif
    auto_run(0, 1'b0, 0);
    tick(); tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_stage_mux_seq.md
Name: fft_stage_mux_seq

Overview:
- Parametrised, registered N:1 stage-operand multiplexer for the 32-point FFT datapath; generalises the fixed 5:1 combinational stage selector.
- Adds a valid/ready handshake and an output register.
- Manual mode: selection comes from a port.
- Auto mode: an internal FSM steps the selector through all stages, advancing after every FRAME_LEN accepted samples.
- Sits between the butterfly stage outputs and the memory write port.

Parameters:
- DATA_WIDTH, 16, width of each data input and of the output.
- NUM_IN, 5, number of selectable inputs (2..8).
- SEL_W, 3, selector width; must satisfy 2^SEL_W >= NUM_IN.
- FRAME_LEN, 32, samples per stage in auto mode (power of two, >= 2).
- CNT_W, 5, sample-counter width; equals log2(FRAME_LEN).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_bus  input  NUM_IN*DATA_WIDTH  packed inputs; input k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- in_valid  input  1  in_bus holds a sample this cycle.
- in_ready  output  1  the block accepts the sample this cycle.
- mode  input  1  0 = manual, 1 = auto.
- sel_manual  input  SEL_W  selector used in manual mode.
- start  input  1  starts an auto sequence; one-cycle pulse.
- y  output  DATA_WIDTH  registered selected sample.
- y_valid  output  1  y holds valid data.
- out_ready  input  1  downstream accepts y.
- cur_sel  output  SEL_W  selector applied to the sample currently being accepted.
- busy  output  1  auto FSM is in RUN.
- frame_done  output  1  one-cycle pulse when the last sample of the last stage is accepted.

Behaviour:
- Reset: y=0, y_valid=0, cur_sel=0, busy=0, frame_done=0, sample counter=0, FSM=IDLE.
- Reset asserted mid-sequence aborts the sequence immediately; no frame_done is produced.
- in_ready = !y_valid || out_ready. The combinational path from out_ready to in_ready is intentional.
- A sample is accepted when in_valid && in_ready, and the transfer is lossless.
- On acceptance: y <= in_bus slice[cur_sel], or 0 if cur_sel >= NUM_IN; y_valid <= 1.
- Otherwise, if out_ready: y_valid <= 0 and y holds its value.
- Latency is 1 cycle from acceptance to y_valid. Full throughput (one sample per cycle) is sustained while out_ready=1.
- Manual mode (mode=0, FSM IDLE): cur_sel = sel_manual, sampled combinationally in the accept cycle. The counter does not move.
- FSM state IDLE:
  - cur_sel = sel_manual when mode=0, else 0.
  - In auto mode, samples are accepted only when busy=1; in_ready=0 in IDLE with mode=1.
  - start && mode=1 -> RUN, with counter=0 and stage=0.
  - start with mode=0 is ignored.
- FSM state RUN:
  - busy=1 and cur_sel = stage register.
  - Each accepted sample increments the counter.
  - When the counter reaches FRAME_LEN-1 on an accepted sample, it wraps to 0 and stage increments.
  - If stage == NUM_IN-1 at that point: frame_done=1 for that cycle, then -> IDLE with stage=0.
  - mode is ignored while in RUN.
  - start while in RUN is ignored and does not restart the sequence.
- An output stall (out_ready=0 with y_valid=1) holds y, the counter and the stage, because nothing is accepted.
- The final sample's y_valid still occurs one cycle after frame_done.

Optional Feature:
- Macro: FFT_MUX_SEL_ERR_EN.
- Defined: adds output sel_err (1 bit, reset 0).
  - Set sticky when a sample is accepted with cur_sel >= NUM_IN.
  - Cleared only by rst.
  - The data output is still forced to 0 in that case.
- Not defined: no sel_err port and no associated logic. Out-of-range selection silently yields 0.

Test Plan:
- Manual select: mode=0, inputs k = 16'h1000+k, sel_manual=3, one valid sample with out_ready=1 -> y=16'h1003 and y_valid=1 the next cycle.
- Out-of-range select: sel_manual=6 with NUM_IN=5 -> y=0. With FFT_MUX_SEL_ERR_EN defined, sel_err=1 and stays 1 until rst.
- Auto sequence: mode=1, start pulse, 160 back-to-back valid samples -> cur_sel steps 0,1,2,3,4 every 32 accepts; frame_done pulses exactly once, on accept #160; busy then drops to 0.
- Backpressure: out_ready=0 for 5 cycles while y_valid=1 -> in_ready=0, y stable, counter frozen; no sample lost or duplicated after release.
- Reset mid-run: assert rst after 40 accepts -> the next cycle shows busy=0, y_valid=0, cur_sel=0; a new start restarts the sequence at stage 0 with count 0.
- start ignored: start pulse at accept #10 of the run -> no restart; frame_done still occurs at accept #160.
